// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU = m0, DMA = m1) arbiter in front of a single memory port.
// Round-robin ties, lockable bursts, in-order read response routing via an owner FIFO.
module mem_port_arbiter #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  input  logic                    m0_req_we,
  input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
  input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_req_be,
  input  logic                    m0_req_lock,
  output logic                    m0_rsp_valid,
  output logic [DATA_WIDTH-1:0]   m0_rsp_rdata,

  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  input  logic                    m1_req_we,
  input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
  input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_req_be,
  input  logic                    m1_req_lock,
  output logic                    m1_rsp_valid,
  output logic [DATA_WIDTH-1:0]   m1_rsp_rdata,

  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,

  output logic                    err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUTSTANDING);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  logic [1:0]                 state;
  logic [1:0]                 state_nxt;
  logic                       last_grant;

  logic                       gnt_id;
  logic                       gnt_valid;
  logic                       gnt_we;
  logic                       gnt_lock;
  logic                       stall;
  logic                       accept;

  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W:0]             occ;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       push;
  logic                       pop;
  logic                       head_id;

  // Grant selection: a lock pins eligibility to its owner even while that owner is idle.
  always_comb begin
    gnt_id    = 1'b0;
    gnt_valid = 1'b0;
    case (state)
      ST_LOCK0: begin
        gnt_id    = 1'b0;
        gnt_valid = m0_req_valid;
      end
      ST_LOCK1: begin
        gnt_id    = 1'b1;
        gnt_valid = m1_req_valid;
      end
      default: begin
        gnt_valid = m0_req_valid | m1_req_valid;
        if (m0_req_valid && m1_req_valid) begin
          gnt_id = ~last_grant;
        end else begin
          gnt_id = m1_req_valid;
        end
      end
    endcase
  end

  assign gnt_we   = gnt_id ? m1_req_we   : m0_req_we;
  assign gnt_lock = gnt_id ? m1_req_lock : m0_req_lock;

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == FULL_CNT);

  // Stall looks at occupancy before this cycle's pop, keeping mem_rvalid off the ready path.
  assign stall  = gnt_valid & ~gnt_we & fifo_full;
  assign accept = gnt_valid & ~stall & ~rst;

  assign m0_req_ready = accept & ~gnt_id;
  assign m1_req_ready = accept &  gnt_id;

  // Memory-side forwarding; fields are zeroed unless a beat is actually issued.
  always_comb begin
    mem_req   = accept;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (accept) begin
      mem_we    = gnt_we;
      mem_addr  = gnt_id ? m1_req_addr  : m0_req_addr;
      mem_wdata = gnt_id ? m1_req_wdata : m0_req_wdata;
      mem_be    = gnt_id ? m1_req_be    : m0_req_be;
    end
  end

  assign push    = accept & ~gnt_we;
  assign pop     = mem_rvalid & ~fifo_empty & ~rst;
  assign head_id = owner_q[rd_ptr];

  assign m0_rsp_valid = pop & ~head_id;
  assign m1_rsp_valid = pop &  head_id;
  assign m0_rsp_rdata = mem_rdata;
  assign m1_rsp_rdata = mem_rdata;

  always_comb begin
    state_nxt = (state == ST_LOCK0 || state == ST_LOCK1) ? state : ST_ARB;
    if (accept) begin
      if (gnt_lock) begin
        state_nxt = gnt_id ? ST_LOCK1 : ST_LOCK0;
      end else begin
        state_nxt = ST_ARB;
      end
    end
  end

  // Control state: FSM, round-robin pointer, FIFO pointers, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ARB;
      last_grant <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      err_o      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= gnt_id;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
      if (mem_rvalid && fifo_empty) begin
        err_o <= 1'b1;
      end
    end
  end

  // Owner IDs are plain storage; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (push) begin
      owner_q[wr_ptr] <= gnt_id;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: queue-based reference model checked every cycle,
// plus literal expectations at the key cycles of each scenario.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int BW = DW/8;
  localparam int MO = 4;

  logic          clk;
  logic          rst;
  logic          m0_req_valid, m0_req_ready, m0_req_we, m0_req_lock, m0_rsp_valid;
  logic [AW-1:0] m0_req_addr;
  logic [DW-1:0] m0_req_wdata, m0_rsp_rdata;
  logic [BW-1:0] m0_req_be;
  logic          m1_req_valid, m1_req_ready, m1_req_we, m1_req_lock, m1_rsp_valid;
  logic [AW-1:0] m1_req_addr;
  logic [DW-1:0] m1_req_wdata, m1_rsp_rdata;
  logic [BW-1:0] m1_req_be;
  logic          mem_req, mem_we, mem_rvalid, err_o;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_be;

  int nvec = 0;
  int nmis = 0;
  int cnum = 0;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_be(m0_req_be),
    .m0_req_lock(m0_req_lock), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_be(m1_req_be),
    .m1_req_lock(m1_req_lock), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cnum, act, exp);
    end
  endtask

  // Reference model: lock owner, last winner, queue of outstanding read owners.
  int lock_to = -1;
  int last = 1;
  int owners[$];
  bit merr = 1'b0;

  always @(negedge clk) begin
    int cand;
    bit cwe, clk_l, acc, e_r0, e_r1, e_v0, e_v1;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [BW-1:0] eb;
    cand = -1; cwe = 0; clk_l = 0; acc = 0;
    e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0;
    if (!rst) begin
      if (lock_to >= 0) begin
        if ((lock_to == 0 && m0_req_valid) || (lock_to == 1 && m1_req_valid)) cand = lock_to;
      end else if (m0_req_valid && m1_req_valid) begin
        cand = 1 - last;
      end else if (m0_req_valid) begin
        cand = 0;
      end else if (m1_req_valid) begin
        cand = 1;
      end
      if (cand >= 0) begin
        cwe   = (cand == 0) ? m0_req_we : m1_req_we;
        clk_l = (cand == 0) ? m0_req_lock : m1_req_lock;
        acc   = cwe || (owners.size() < MO);
      end
      e_r0 = acc && cand == 0;
      e_r1 = acc && cand == 1;
      if (mem_rvalid && owners.size() > 0) begin
        e_v0 = (owners[0] == 0);
        e_v1 = (owners[0] == 1);
      end
    end
    check("m0_req_ready", m0_req_ready, e_r0);
    check("m1_req_ready", m1_req_ready, e_r1);
    check("mem_req", mem_req, acc);
    if (acc) begin
      ea = (cand == 0) ? m0_req_addr  : m1_req_addr;
      ed = (cand == 0) ? m0_req_wdata : m1_req_wdata;
      eb = (cand == 0) ? m0_req_be    : m1_req_be;
      check("mem_we", mem_we, cwe);
      check("mem_addr", mem_addr, ea);
      check("mem_wdata", mem_wdata, ed);
      check("mem_be", mem_be, eb);
    end
    check("m0_rsp_valid", m0_rsp_valid, e_v0);
    check("m1_rsp_valid", m1_rsp_valid, e_v1);
    check("m0_rsp_rdata", m0_rsp_rdata, mem_rdata);
    check("m1_rsp_rdata", m1_rsp_rdata, mem_rdata);
    check("err_o", err_o, merr);
    if (rst) begin
      lock_to = -1;
      last = 1;
      owners.delete();
      merr = 1'b0;
    end else begin
      if (mem_rvalid) begin
        if (owners.size() == 0) merr = 1'b1;
        else void'(owners.pop_front());
      end
      if (acc) begin
        last = cand;
        lock_to = clk_l ? cand : -1;
        if (!cwe) owners.push_back(cand);
      end
    end
  end

  // One cycle of stimulus; returns at the following falling edge so callers can sample.
  task automatic cyc(input bit r, input bit v0, input bit w0, input bit l0,
                     input bit v1, input bit w1, input bit l1, input bit rv);
    @(posedge clk);
    #1;
    cnum++;
    rst          = r;
    m0_req_valid = v0;  m0_req_we = w0;  m0_req_lock = l0;
    m1_req_valid = v1;  m1_req_we = w1;  m1_req_lock = l1;
    m0_req_addr  = AW'(16'h1000 + cnum);
    m1_req_addr  = AW'(16'h2000 + cnum);
    m0_req_wdata = 32'hA000_0000 + DW'(cnum);
    m1_req_wdata = 32'hB000_0000 + DW'(cnum);
    m0_req_be    = BW'(4'h3 ^ cnum[3:0]);
    m1_req_be    = BW'(4'hC ^ cnum[3:0]);
    mem_rvalid   = rv;
    mem_rdata    = 32'hD000_0000 + DW'(cnum);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    m0_req_valid = 0; m0_req_we = 0; m0_req_lock = 0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_be = '0;
    m1_req_valid = 0; m1_req_we = 0; m1_req_lock = 0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_be = '0;
    mem_rvalid = 0; mem_rdata = '0;

    // reset: outputs quiet even with valid requests and a read return
    cyc(1, 1,0,0, 1,1,0, 0);
    check("rst_r0", m0_req_ready, 0);
    check("rst_r1", m1_req_ready, 0);
    check("rst_mreq", mem_req, 0);
    check("rst_err", err_o, 0);
    cyc(1, 0,0,0, 0,0,0, 1);
    check("rst_rsp0", m0_rsp_valid, 0);
    check("rst_rsp1", m1_rsp_valid, 0);

    // first tie goes to m0; latency-2 returns route in order
    cyc(0, 1,0,0, 1,0,0, 0);
    check("t17_c0_r0", m0_req_ready, 1);
    check("t17_c0_r1", m1_req_ready, 0);
    cyc(0, 0,0,0, 1,0,0, 0);
    check("t17_c1_r1", m1_req_ready, 1);
    cyc(0, 0,0,0, 0,0,0, 1);
    check("t17_c2_rsp0", m0_rsp_valid, 1);
    check("t17_c2_rsp1", m1_rsp_valid, 0);
    cyc(0, 0,0,0, 0,0,0, 1);
    check("t17_c3_rsp1", m1_rsp_valid, 1);
    check("t17_c3_rsp0", m0_rsp_valid, 0);

    // m1 4-beat locked write burst against a continuously valid m0
    cyc(0, 1,1,0, 0,0,0, 0);
    check("t18_pre_r0", m0_req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1,1,0, 1,1,(i < 3), 0);
      check("t18_burst_r1", m1_req_ready, 1);
      check("t18_burst_r0", m0_req_ready, 0);
      check("t18_burst_addr", mem_addr, AW'(16'h2000 + cnum));
    end
    cyc(0, 1,1,0, 1,1,0, 0);
    check("t18_after_r0", m0_req_ready, 1);

    // LOCK0 holds m1 off while m0 is idle
    cyc(0, 1,1,1, 0,0,0, 0);
    check("t19_lock_r0", m0_req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0,0,0, 1,1,0, 0);
      check("t19_hold_r1", m1_req_ready, 0);
      check("t19_hold_mreq", mem_req, 0);
    end
    cyc(0, 1,1,0, 1,1,0, 0);
    check("t19_end_r0", m0_req_ready, 1);
    cyc(0, 0,0,0, 1,1,0, 0);
    check("t19_free_r1", m1_req_ready, 1);

    // outstanding limit: 4 reads, 5th stalls until the cycle after a return
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1,0,0, 0,0,0, 0);
      check("t20_fill_r0", m0_req_ready, 1);
    end
    cyc(0, 1,0,0, 0,0,0, 0);
    check("t20_stall_r0", m0_req_ready, 0);
    check("t20_stall_mreq", mem_req, 0);
    cyc(0, 1,0,0, 0,0,0, 1);
    check("t20_pop_rsp0", m0_rsp_valid, 1);
    check("t20_pop_r0", m0_req_ready, 0);
    cyc(0, 1,0,0, 0,0,0, 0);
    check("t20_refill_r0", m0_req_ready, 1);
    cyc(0, 1,0,0, 0,0,0, 0);
    check("t20_full_again_r0", m0_req_ready, 0);
    cyc(0, 0,0,0, 1,1,0, 0);
    check("t20_write_full_r1", m1_req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0,0,0, 0,0,0, 1);
      check("t20_drain_rsp0", m0_rsp_valid, 1);
    end

    // simultaneous push and pop keeps order
    cyc(0, 1,0,0, 0,0,0, 0);
    check("t12_r0", m0_req_ready, 1);
    cyc(0, 0,0,0, 1,0,0, 1);
    check("t12_rsp0", m0_rsp_valid, 1);
    check("t12_r1", m1_req_ready, 1);
    cyc(0, 0,0,0, 0,0,0, 1);
    check("t12_rsp1", m1_rsp_valid, 1);
    check("t12_err", err_o, 0);

    // spurious return sets sticky error
    cyc(0, 0,0,0, 0,0,0, 1);
    check("t21_rsp0", m0_rsp_valid, 0);
    check("t21_rsp1", m1_rsp_valid, 0);
    cyc(0, 0,0,0, 0,0,0, 0);
    check("t21_err", err_o, 1);
    cyc(0, 0,0,0, 0,0,0, 0);
    check("t21_err_held", err_o, 1);

    // reset with 3 reads outstanding in LOCK1
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0,0,0, 1,0,1, 0);
      check("t22_lockrd_r1", m1_req_ready, 1);
    end
    cyc(1, 1,0,0, 1,0,0, 0);
    check("t22_rst_r0", m0_req_ready, 0);
    check("t22_rst_r1", m1_req_ready, 0);
    check("t22_rst_err", err_o, 1);
    cyc(0, 1,0,0, 1,0,0, 0);
    check("t22_tie_r0", m0_req_ready, 1);
    check("t22_tie_r1", m1_req_ready, 0);
    check("t22_err_clr", err_o, 0);
    cyc(0, 0,0,0, 1,0,0, 1);
    check("t22_rsp0", m0_rsp_valid, 1);
    check("t22_rsp1", m1_rsp_valid, 0);
    check("t22_r1", m1_req_ready, 1);
    cyc(0, 0,0,0, 0,0,0, 1);
    check("t22_rsp1b", m1_rsp_valid, 1);
    cyc(0, 0,0,0, 0,0,0, 0);
    check("t22_err_final", err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
